// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
//   lsu_state_e    : LSU sequencing states
//   F3_*           : funct3 access size/sign encodings
//   store_be       : byte enables for a store of a given size at a byte offset
//   store_wdata    : lane-replicated store data
//   is_misaligned  : natural-alignment test, used only when MEM_LSU_MISALIGN_TRAP_EN is defined
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Size lives in funct3[1:0]; 2'b11 is treated as a word access.
    function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << addr_lo;
            2'b01:   be = 4'b0011 << {addr_lo[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] funct3, input logic [31:0] data);
        logic [31:0] wdata;
        case (funct3[1:0])
            2'b00:   wdata = {4{data[7:0]}};
            2'b01:   wdata = {2{data[15:0]}};
            default: wdata = data;
        endcase
        return wdata;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        case (funct3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the LSU (master) and a multi-cycle dmem (slave).
//   dmem_req/we/addr/wdata/be : request, held by the master until dmem_gnt
//   dmem_gnt                  : request accepted this cycle
//   dmem_rvalid/rdata         : read response, earliest the cycle after gnt
interface mem_stage_lsu_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_be,
        input  dmem_gnt,
        input  dmem_rvalid,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_be,
        output dmem_gnt,
        output dmem_rvalid,
        output dmem_rdata
    );

endinterface

// File: rtl/load_align_ext.sv
// Combinational load alignment: picks the byte/half lane addressed by addr_lo_i out of the
// raw memory word and sign- or zero-extends it according to funct3_i.
//   rdata_i   : raw 32-bit read word
//   addr_lo_i : byte offset within the word
//   funct3_i  : access size/sign (unlisted encodings return the whole word)
//   result_o  : aligned, extended load result
module load_align_ext
    import riscv_mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = 8'h00;
        unique case (addr_lo_i)
            2'd0: byte_lane = rdata_i[7:0];
            2'd1: byte_lane = rdata_i[15:8];
            2'd2: byte_lane = rdata_i[23:16];
            2'd3: byte_lane = rdata_i[31:24];
        endcase
    end

    // addr_lo_i[0] is ignored for halves; misalignment is handled upstream.
    assign half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        result_o = rdata_i;
        case (funct3_i)
            F3_LB:   result_o = {{24{byte_lane[7]}}, byte_lane};
            F3_LH:   result_o = {{16{half_lane[15]}}, half_lane};
            F3_LBU:  result_o = {24'h0, byte_lane};
            F3_LHU:  result_o = {16'h0, half_lane};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit. Takes the EX/MEM access, runs a req/gnt + rvalid handshake
// on the dmem bus, stalls the pipeline until the access completes and hands aligned load
// data to MEM/WB for one cycle.
//   clk, reset         : clock, synchronous active-high reset
//   execute_out_m      : byte address;  reg_readdata2_m : store data
//   dmem_read_en_m     : load;  dmem_write_en_m : store (a load wins if both are set)
//   mem_funct3_m       : access size/sign
//   bus                : dmem master port (mem_stage_lsu_if)
//   mem_stall          : hold EX/MEM and upstream stages
//   load_data_m        : aligned/extended load result, valid with load_valid_m
//   bus_err_m          : one-cycle pulse on response timeout (load_data_m forced to 0)
//   misalign_m         : one-cycle pulse on a misaligned access
// Parameter RESP_TIMEOUT: WAIT cycles without rvalid before a bus error; 0 disables.
// Define MEM_LSU_MISALIGN_TRAP_EN to reject misaligned H/W accesses without touching the bus;
// otherwise misalign_m stays 0 and the sub-alignment address bits are ignored.
module mem_stage_lsu
    import riscv_mem_pkg::*;
#(
    parameter int unsigned RESP_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            execute_out_m,
    input  logic [31:0]            reg_readdata2_m,
    input  logic                   dmem_read_en_m,
    input  logic                   dmem_write_en_m,
    input  logic [2:0]             mem_funct3_m,
    mem_stage_lsu_if.master        bus,
    output logic                   mem_stall,
    output logic [31:0]            load_data_m,
    output logic                   load_valid_m,
    output logic                   bus_err_m,
    output logic                   misalign_m
);

    localparam int unsigned CntW = (RESP_TIMEOUT == 0) ? 1 : $clog2(RESP_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(RESP_TIMEOUT - 1);

    lsu_state_e      state_q;
    logic            req_q;
    logic            we_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      be_q;
    logic [1:0]      addr_lo_q;
    logic [2:0]      funct3_q;
    logic [CntW-1:0] wait_cnt_q;
    logic [31:0]     load_data_q;
    logic            load_valid_q;
    logic            bus_err_q;
    logic            misalign_q;

    logic            access;
    logic            is_store;
    logic            misaligned;
    logic [31:0]     aligned_data;

    assign access   = dmem_read_en_m | dmem_write_en_m;
    assign is_store = dmem_write_en_m & ~dmem_read_en_m;

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    assign misaligned = access & is_misaligned(mem_funct3_m, execute_out_m[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    load_align_ext u_load_align_ext (
        .rdata_i   (bus.dmem_rdata),
        .addr_lo_i (addr_lo_q),
        .funct3_i  (funct3_q),
        .result_o  (aligned_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            be_q         <= 4'h0;
            addr_lo_q    <= 2'b00;
            funct3_q     <= 3'b000;
            wait_cnt_q   <= '0;
            load_data_q  <= 32'h0;
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
            misalign_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (misaligned) begin
                        misalign_q <= 1'b1;
                    end else if (access) begin
                        req_q     <= 1'b1;
                        we_q      <= is_store;
                        addr_q    <= {execute_out_m[31:2], 2'b00};
                        wdata_q   <= store_wdata(mem_funct3_m, reg_readdata2_m);
                        be_q      <= store_be(mem_funct3_m, execute_out_m[1:0]);
                        addr_lo_q <= execute_out_m[1:0];
                        funct3_q  <= mem_funct3_m;
                        state_q   <= StReq;
                    end
                end
                StReq: begin
                    if (bus.dmem_gnt) begin
                        req_q      <= 1'b0;
                        wait_cnt_q <= '0;
                        state_q    <= we_q ? StDone : StWait;
                    end
                end
                StWait: begin
                    if (bus.dmem_rvalid) begin
                        load_data_q  <= aligned_data;
                        load_valid_q <= 1'b1;
                        state_q      <= StDone;
                    end else if ((RESP_TIMEOUT != 0) && (wait_cnt_q == CntLast)) begin
                        load_data_q  <= 32'h0;
                        load_valid_q <= 1'b1;
                        bus_err_q    <= 1'b1;
                        state_q      <= StDone;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                // The instruction leaves MEM this cycle; never re-issue from here.
                StDone: state_q <= StIdle;
            endcase
        end
    end

    assign mem_stall = ((state_q == StIdle) & access & ~misaligned)
                     | (state_q == StReq)
                     | (state_q == StWait);

    assign bus.dmem_req   = req_q;
    assign bus.dmem_we    = we_q;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_wdata = wdata_q;
    assign bus.dmem_be    = be_q;

    assign load_data_m  = load_data_q;
    assign load_valid_m = load_valid_q;
    assign bus_err_m    = bus_err_q;
    assign misalign_m   = misalign_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;
    import riscv_mem_pkg::*;

    localparam int unsigned RespTimeout = 8;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] execute_out_m;
    logic [31:0] reg_readdata2_m;
    logic        dmem_read_en_m;
    logic        dmem_write_en_m;
    logic [2:0]  mem_funct3_m;
    logic        mem_stall;
    logic [31:0] load_data_m;
    logic        load_valid_m;
    logic        bus_err_m;
    logic        misalign_m;

    mem_stage_lsu_if bus_if ();

    mem_stage_lsu #(
        .RESP_TIMEOUT (RespTimeout)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .execute_out_m   (execute_out_m),
        .reg_readdata2_m (reg_readdata2_m),
        .dmem_read_en_m  (dmem_read_en_m),
        .dmem_write_en_m (dmem_write_en_m),
        .mem_funct3_m    (mem_funct3_m),
        .bus             (bus_if),
        .mem_stall       (mem_stall),
        .load_data_m     (load_data_m),
        .load_valid_m    (load_valid_m),
        .bus_err_m       (bus_err_m),
        .misalign_m      (misalign_m)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    bus_txn_t    bus_q[$];
    logic [31:0] load_q[$];
    int          gnt_dly = 0;
    int          rv_dly = 1;
    logic [31:0] rd_word = 32'h0;
    int          lv_count = 0;
    int          berr_count = 0;
    bit          expect_berr = 1'b0;
    logic [2:0]  load_f3 [5] = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model, built byte-by-byte rather than with shifted masks.
    function automatic int acc_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] a);
        int sz = acc_size(f3);
        int lo = int'(a) & ~(sz - 1);
        logic [3:0] be = 4'h0;
        for (int k = 0; k < 4; k++) be[k] = (k >= lo) && (k < lo + sz);
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        int sz = acc_size(f3);
        logic [31:0] w = 32'h0;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = d[8*(k % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
        logic [31:0] b = w >> (8 * int'(a));
        logic [31:0] h = w >> (16 * int'(a[1]));
        case (f3)
            3'b000:  return {{24{b[7]}}, b[7:0]};
            3'b001:  return {{16{h[15]}}, h[15:0]};
            3'b100:  return {24'h0, b[7:0]};
            3'b101:  return {16'h0, h[15:0]};
            default: return w;
        endcase
    endfunction

    // dmem responder: grants after gnt_dly REQ cycles, answers loads rv_dly cycles later
    // (rv_dly = 0: never). Checks each presented request against the scoreboard head.
    initial begin
        int gcnt = -1;
        int rcnt = 0;
        bus_if.dmem_gnt    = 1'b0;
        bus_if.dmem_rvalid = 1'b0;
        bus_if.dmem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus_if.dmem_gnt    = 1'b0;
            bus_if.dmem_rvalid = 1'b0;
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    bus_if.dmem_rvalid = 1'b1;
                    bus_if.dmem_rdata  = rd_word;
                end
            end
            if (bus_if.dmem_req) begin
                if (bus_q.size() == 0) begin
                    check_eq("spurious_req", 32'(bus_if.dmem_req), 32'd0);
                end else begin
                    check_eq("req_we", 32'(bus_if.dmem_we), 32'(bus_q[0].we));
                    check_eq("req_addr", bus_if.dmem_addr, bus_q[0].addr);
                    if (bus_q[0].we) begin
                        check_eq("req_be", 32'(bus_if.dmem_be), 32'(bus_q[0].be));
                        check_eq("req_wdata", bus_if.dmem_wdata, bus_q[0].wdata);
                    end
                    if (gcnt < 0) gcnt = gnt_dly;
                    if (gcnt == 0) begin
                        bus_if.dmem_gnt = 1'b1;
                        gcnt = -1;
                        if (!bus_q[0].we && rv_dly > 0) rcnt = rv_dly;
                        void'(bus_q.pop_front());
                    end else begin
                        gcnt--;
                    end
                end
            end
        end
    end

    // Output monitor: pops expected load results, watches for bus errors.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (load_valid_m && !bus_err_m) begin
                    lv_count++;
                    if (load_q.size() == 0) check_eq("spurious_load_valid", 32'(load_valid_m), 32'd0);
                    else check_eq("load_data", load_data_m, load_q.pop_front());
                end
                if (bus_err_m) begin
                    berr_count++;
                    check_eq("berr_load_data", load_data_m, 32'h0);
                    if (!expect_berr) check_eq("spurious_bus_err", 32'(bus_err_m), 32'd0);
                end
            end
        end
    end

    task automatic run_access(input logic re, input logic we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] d,
                              input int exp_stall, input string tag);
        int stalls = 0;
        @(posedge clk);
        #1;
        dmem_read_en_m  = re;
        dmem_write_en_m = we;
        mem_funct3_m    = f3;
        execute_out_m   = a;
        reg_readdata2_m = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mem_stall) stalls++;
            else break;
        end
        check_eq({tag, "_stall_release"}, 32'(mem_stall), 32'd0);
        if (exp_stall >= 0) check_eq({tag, "_stalls"}, 32'(stalls), 32'(exp_stall));
        @(posedge clk);
        #1;
        dmem_read_en_m  = 1'b0;
        dmem_write_en_m = 1'b0;
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input int exp_stall, input string tag);
        bus_q.push_back('{we: 1'b1, addr: a & ~32'h3, wdata: exp_wdata, be: exp_be});
        run_access(1'b0, 1'b1, f3, a, d, exp_stall, tag);
    endtask

    task automatic do_load(input logic re_we_both, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rdata, input logic [31:0] exp_data,
                           input int exp_stall, input string tag);
        rd_word = rdata;
        bus_q.push_back('{we: 1'b0, addr: a & ~32'h3, wdata: 32'h0, be: 4'h0});
        load_q.push_back(exp_data);
        run_access(1'b1, re_we_both, f3, a, 32'h5555_5555, exp_stall, tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lv0;
        int be0;
        reset           = 1'b1;
        execute_out_m   = 32'h0;
        reg_readdata2_m = 32'h0;
        dmem_read_en_m  = 1'b0;
        dmem_write_en_m = 1'b0;
        mem_funct3_m    = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_req", 32'(bus_if.dmem_req), 32'd0);
        check_eq("rst_we", 32'(bus_if.dmem_we), 32'd0);
        check_eq("rst_addr", bus_if.dmem_addr, 32'h0);
        check_eq("rst_wdata", bus_if.dmem_wdata, 32'h0);
        check_eq("rst_be", 32'(bus_if.dmem_be), 32'd0);
        check_eq("rst_load_data", load_data_m, 32'h0);
        check_eq("rst_load_valid", 32'(load_valid_m), 32'd0);
        check_eq("rst_bus_err", 32'(bus_err_m), 32'd0);
        check_eq("rst_misalign", 32'(misalign_m), 32'd0);
        check_eq("rst_stall", 32'(mem_stall), 32'd0);

        // Stores: no load_valid may appear.
        lv0 = lv_count;
        do_store(3'b010, 32'h100, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF, 2, "sw");
        do_store(3'b000, 32'h103, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, 2, "sb");
        do_store(3'b001, 32'h102, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF, 2, "sh");
        check_eq("store_no_load_valid", 32'(lv_count - lv0), 32'd0);

        // Loads at minimum latency.
        do_load(1'b0, F3_LB, 32'h102, 32'h0080_0000, 32'hFFFF_FF80, 3, "lb");
        do_load(1'b0, F3_LBU, 32'h102, 32'h0080_0000, 32'h0000_0080, 3, "lbu");
        do_load(1'b0, F3_LH, 32'h102, 32'h8001_0000, 32'hFFFF_8001, 3, "lh");
        do_load(1'b0, F3_LHU, 32'h100, 32'h1234_F00D, 32'h0000_F00D, 3, "lhu");
        do_load(1'b0, 3'b111, 32'h104, 32'h8765_4321, 32'h8765_4321, 3, "f3_111_word");
        // Read and write together behave as a load.
        do_load(1'b1, F3_LW, 32'h108, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 3, "rw_both");

        // Slow slave: 4 cycles to gnt, 3 more to rvalid.
        gnt_dly = 4;
        rv_dly  = 3;
        lv0     = lv_count;
        do_load(1'b0, F3_LW, 32'h200, 32'hCAFE_F00D, 32'hCAFE_F00D, 9, "slow");
        check_eq("slow_one_pulse", 32'(lv_count - lv0), 32'd1);

        // No response at all: timeout after RespTimeout WAIT cycles.
        gnt_dly     = 0;
        rv_dly      = 0;
        expect_berr = 1'b1;
        be0         = berr_count;
        bus_q.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0, be: 4'h0});
        run_access(1'b1, 1'b0, F3_LW, 32'h300, 32'h0, 2 + int'(RespTimeout), "timeout");
        check_eq("timeout_one_berr", 32'(berr_count - be0), 32'd1);
        expect_berr = 1'b0;

        // Reset while waiting for rvalid; the late response must be dropped.
        rv_dly  = 5;
        rd_word = 32'h1111_1111;
        lv0     = lv_count;
        bus_q.push_back('{we: 1'b0, addr: 32'h400, wdata: 32'h0, be: 4'h0});
        @(posedge clk);
        #1;
        dmem_read_en_m = 1'b1;
        mem_funct3_m   = F3_LW;
        execute_out_m  = 32'h400;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rstw_in_wait_stall", 32'(mem_stall), 32'd1);
        reset          = 1'b1;
        dmem_read_en_m = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("rstw_req", 32'(bus_if.dmem_req), 32'd0);
        check_eq("rstw_stall", 32'(mem_stall), 32'd0);
        repeat (6) @(negedge clk);
        check_eq("rstw_no_load_valid", 32'(lv_count - lv0), 32'd0);
        rv_dly = 1;
        do_load(1'b0, F3_LB, 32'h401, 32'h0000_7F00, 32'h0000_007F, 3, "after_rst");

`ifdef MEM_LSU_MISALIGN_TRAP_EN
        @(posedge clk);
        #1;
        dmem_read_en_m = 1'b1;
        mem_funct3_m   = F3_LW;
        execute_out_m  = 32'h102;
        @(negedge clk);
        check_eq("mis_stall", 32'(mem_stall), 32'd0);
        @(posedge clk);
        #1;
        dmem_read_en_m = 1'b0;
        @(negedge clk);
        check_eq("mis_pulse", 32'(misalign_m), 32'd1);
        check_eq("mis_no_req", 32'(bus_if.dmem_req), 32'd0);
        @(negedge clk);
        check_eq("mis_pulse_end", 32'(misalign_m), 32'd0);
`else
        do_load(1'b0, F3_LW, 32'h102, 32'h89AB_CDEF, 32'h89AB_CDEF, 3, "lw_unaligned");
        check_eq("no_misalign", 32'(misalign_m), 32'd0);
`endif

        // Mixed traffic against the reference model.
        for (int i = 0; i < 12; i++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] d;
            gnt_dly = $urandom_range(0, 2);
            rv_dly  = $urandom_range(1, 3);
            d       = $urandom;
            a       = 32'h800 + 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                f3 = 3'($urandom_range(0, 2));
                a  = a & ~32'(acc_size(f3) - 1);
                do_store(f3, a, d, m_be(f3, a[1:0]), m_wdata(f3, d), -1, "rnd_store");
            end else begin
                f3 = load_f3[$urandom_range(0, 4)];
                a  = a & ~32'(acc_size(f3) - 1);
                do_load(1'b0, f3, a, d, m_load(f3, a[1:0], d), -1, "rnd_load");
            end
        end

        repeat (4) @(negedge clk);
        check_eq("bus_q_drained", 32'(bus_q.size()), 32'd0);
        check_eq("load_q_drained", 32'(load_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
